// File: rtl/commit_trace_if.sv
// commit_trace_if: retirement commit channel in, trace record channel out
interface commit_trace_if #(
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
);
  logic              commit_valid;
  logic [31:0]       commit_pc;
  logic [31:0]       commit_instr;
  logic              commit_wr;
  logic [4:0]        commit_dst;
  logic [31:0]       commit_dst_val;
  logic              commit_is_r;
  logic              commit_is_i;
  logic [31:0]       v0_val;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc;
  logic [31:0]       trace_instr;
  logic [4:0]        trace_dst;
  logic [31:0]       trace_dst_val;
  logic [1:0]        trace_type;
  logic [SEQ_W-1:0]  trace_seq;
  logic              stall_cpu;
  logic [DROP_W-1:0] drop_cnt;
  logic              done;
  modport master (
    input  commit_valid, commit_pc, commit_instr, commit_wr, commit_dst, commit_dst_val,
           commit_is_r, commit_is_i, v0_val, trace_ready,
    output trace_valid, trace_pc, trace_instr, trace_dst, trace_dst_val, trace_type,
           trace_seq, stall_cpu, drop_cnt, done
  );
  modport slave (
    output commit_valid, commit_pc, commit_instr, commit_wr, commit_dst, commit_dst_val,
           commit_is_r, commit_is_i, v0_val, trace_ready,
    input  trace_valid, trace_pc, trace_instr, trace_dst, trace_dst_val, trace_type,
           trace_seq, stall_cpu, drop_cnt, done
  );
endinterface

// File: rtl/commit_trace_port.sv
// commit_trace_port: FIFO of retirement records for a checker, draining to done after the exit syscall
// Define TRACE_STALL_EN to hold the core when full instead of dropping records.
module commit_trace_port #(
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
) (
  input logic clk,
  input logic reset,
  commit_trace_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 32 + 32 + 5 + 32 + 2 + SEQ_W;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] wrec, hrec;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count, cnt_nxt;
  logic [SEQ_W-1:0] seq;
  logic full, pop, push, take, accept, is_exit, stall;
  logic [1:0] typ;
  always_comb begin
    full    = count == CW'(DEPTH);
    pop     = bus.trace_valid && bus.trace_ready;
    take    = bus.commit_valid && state == RUN;
    push    = take && (!full || pop);
    cnt_nxt = count + CW'(push) - CW'(pop);
    is_exit = bus.commit_instr == 32'h0000000c && bus.v0_val == 32'h0000000a;
    typ     = is_exit ? 2'b11 : bus.commit_is_r ? 2'b01 : bus.commit_is_i ? 2'b10 : 2'b00;
    wrec    = {bus.commit_pc, bus.commit_instr, bus.commit_wr ? bus.commit_dst : 5'd0,
               bus.commit_wr ? bus.commit_dst_val : 32'd0, typ, seq};
  end
`ifdef TRACE_STALL_EN
  assign accept = push;
  assign stall  = full && !pop;
  assign bus.drop_cnt = '0;
  always_ff @(posedge clk)
    if (!reset) assert (!(bus.commit_valid && stall));
`else
  // A commit that finds the FIFO full still consumes a sequence number so the gap is visible.
  logic [DROP_W-1:0] drop;
  assign accept = take;
  assign stall  = 1'b0;
  assign bus.drop_cnt = drop;
  always_ff @(posedge clk)
    if (reset)
      drop <= '0;
    else if (take && !push && drop != '1)
      drop <= drop + 1'b1;
`endif
  assign bus.stall_cpu = stall;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == RUN && accept && is_exit) ? DRAIN :
                (state == DRAIN && cnt_nxt == '0) ? DONE : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      seq   <= '0;
    end else begin
      state <= state_nxt;
      count <= cnt_nxt;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (accept) seq <= seq + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wrec;
  assign bus.trace_valid = count != '0 && state != DONE;
  assign bus.done        = state == DONE;
  assign hrec            = bus.trace_valid ? mem[rp] : '0;
  assign {bus.trace_pc, bus.trace_instr, bus.trace_dst, bus.trace_dst_val,
          bus.trace_type, bus.trace_seq} = hrec;
endmodule
